// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: recovers four channels (a,b,c,d) from a time-multiplexed
// sample stream framed by a start-of-frame marker on the channel-a slot.
// A frame is collected in shadow registers and presented on ch_a..ch_d in
// one step, so a partial frame never reaches the outputs.
module tdm_demux_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_sof,
    output logic [WIDTH-1:0] ch_a,
    output logic [WIDTH-1:0] ch_b,
    output logic [WIDTH-1:0] ch_c,
    output logic [WIDTH-1:0] ch_d,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic             locked,
    output logic             frame_err,
    output logic [7:0]       frame_cnt
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 sel_q, sel_d;
    logic [2:0][WIDTH-1:0]      shadow_q, shadow_d;
    logic [3:0][WIDTH-1:0]      ch_q, ch_d_nx;
    logic                       out_valid_q, out_valid_d;
    logic                       frame_err_q, frame_err_d;
    logic [7:0]                 frame_cnt_q, frame_cnt_d;

    // Next-state and next-output decode for one accepted sample.
    // NOTE: every signal gets a default first so no path leaves a value
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        shadow_d    = shadow_q;
        ch_d_nx     = ch_q;
        frame_cnt_d = frame_cnt_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    // Unsynchronised samples are dropped silently.
                    if (din_sof) begin
                        shadow_d[0] = din;
                        sel_d       = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sel_q == 2'd0) begin
                        if (din_sof) begin
                            shadow_d[0] = din;
                            sel_d       = 2'd1;
                        end else begin
                            // Missing sync: drop sample and go back to hunting.
                            frame_err_d = 1'b1;
                            sel_d       = 2'd0;
                            state_d     = HUNT;
                        end
                    end else if (din_sof) begin
                        // Early sync: abandon the partial frame, restart on this one.
                        frame_err_d = 1'b1;
                        shadow_d[0] = din;
                        sel_d       = 2'd1;
                    end else begin
                        unique case (sel_q)
                            2'd1: shadow_d[1] = din;
                            2'd2: shadow_d[2] = din;
                            default: begin
                                // Slot d completes the frame; publish all four at once.
                                ch_d_nx[0]  = shadow_q[0];
                                ch_d_nx[1]  = shadow_q[1];
                                ch_d_nx[2]  = shadow_q[2];
                                ch_d_nx[3]  = din;
                                out_valid_d = 1'b1;
                                frame_cnt_d = frame_cnt_q + 8'd1;
                            end
                        endcase
                        sel_d = sel_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    sel_d   = 2'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset taking priority.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow array is only three words, so it is reset like
            // any other register; that also keeps stale data from leaking out.
            state_q     <= HUNT;
            sel_q       <= 2'd0;
            shadow_q    <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            ch_q        <= ch_d_nx;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign ch_a      = ch_q[0];
    assign ch_b      = ch_q[1];
    assign ch_c      = ch_q[2];
    assign ch_d      = ch_q[3];
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign sel       = sel_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4: a queue-based frame model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_tdm_demux_1to4;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_sof;
    logic [WIDTH-1:0] ch_a, ch_b, ch_c, ch_d;
    logic             out_valid;
    logic [1:0]       sel;
    logic             locked;
    logic             frame_err;
    logic [7:0]       frame_cnt;

    tdm_demux_1to4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .ch_a      (ch_a),
        .ch_b      (ch_b),
        .ch_c      (ch_c),
        .ch_d      (ch_d),
        .out_valid (out_valid),
        .sel       (sel),
        .locked    (locked),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ov_seen = 0;

    // Model: the samples of the frame in progress, whether we are synced,
    // and the values the outputs must show after the current edge.
    logic [WIDTH-1:0] m_frame[$];
    bit               m_locked;
    logic [WIDTH-1:0] m_ch[4];
    bit               m_ov;
    bit               m_err;
    int               m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_frame.delete();
            m_locked = 1'b0;
            for (int i = 0; i < 4; i++) m_ch[i] = '0;
            m_cnt = 0;
        end else if (din_valid) begin
            if (din_sof) begin
                if (m_frame.size() != 0) m_err = 1'b1;
                m_frame.delete();
                m_frame.push_back(din);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (m_frame.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    m_frame.push_back(din);
                    if (m_frame.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_ch[i] = m_frame[i];
                        m_ov  = 1'b1;
                        m_cnt = (m_cnt + 1) % 256;
                        m_frame.delete();
                    end
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check("ch_a", 32'(ch_a), 32'(m_ch[0]));
        check("ch_b", 32'(ch_b), 32'(m_ch[1]));
        check("ch_c", 32'(ch_c), 32'(m_ch[2]));
        check("ch_d", 32'(ch_d), 32'(m_ch[3]));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("frame_err", 32'(frame_err), 32'(m_err));
        check("locked", 32'(locked), 32'(m_locked));
        check("sel", 32'(sel), 32'(m_frame.size()));
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic tick(input bit r, input bit v, input bit s, input logic [WIDTH-1:0] d);
        rst       = r;
        din_valid = v;
        din_sof   = s;
        din       = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
        if (out_valid === 1'b1) ov_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, ($urandom % 2) == 1, WIDTH'($urandom));
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
                              input bit gaps);
        logic [WIDTH-1:0] s[4];
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (gaps && i != 0) idle(int'($urandom_range(1, 3)));
            tick(1'b0, 1'b1, i == 0, s[i]);
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; din = '0;

        // Reset state
        tick(1'b1, 1'b1, 1'b1, 8'h5A);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_ch_a", 32'(ch_a), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'h0);

        // Back-to-back frame
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        check("f1_out_valid", 32'(out_valid), 32'h1);
        check("f1_ch_a", 32'(ch_a), 32'h11);
        check("f1_ch_b", 32'(ch_b), 32'h22);
        check("f1_ch_c", 32'(ch_c), 32'h33);
        check("f1_ch_d", 32'(ch_d), 32'h44);
        check("f1_frame_cnt", 32'(frame_cnt), 32'h1);
        idle(1);
        check("f1_pulse_end", 32'(out_valid), 32'h0);

        // Same frame with idle gaps: exactly one out_valid
        ov_seen = 0;
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        idle(3);
        check("gap_ov_count", 32'(ov_seen), 32'h1);
        check("gap_ch_d", 32'(ch_d), 32'h44);
        check("gap_frame_cnt", 32'(frame_cnt), 32'h2);

        // Hunt: unsynced samples ignored without error
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'hAA);
        check("hunt_no_err", 32'(frame_err), 32'h0);
        tick(1'b0, 1'b1, 1'b0, 8'hBB);
        check("hunt_locked", 32'(locked), 32'h0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        check("hunt_ch_a", 32'(ch_a), 32'h01);
        check("hunt_ch_d", 32'(ch_d), 32'h04);

        // Early sync
        ov_seen = 0;
        tick(1'b0, 1'b1, 1'b1, 8'h10);
        tick(1'b0, 1'b1, 1'b0, 8'h20);
        tick(1'b0, 1'b1, 1'b1, 8'h50);
        check("early_err", 32'(frame_err), 32'h1);
        check("early_locked", 32'(locked), 32'h1);
        tick(1'b0, 1'b1, 1'b0, 8'h60);
        tick(1'b0, 1'b1, 1'b0, 8'h70);
        tick(1'b0, 1'b1, 1'b0, 8'h80);
        check("early_ov_count", 32'(ov_seen), 32'h1);
        check("early_ch_a", 32'(ch_a), 32'h50);
        check("early_ch_d", 32'(ch_d), 32'h80);

        // Missing sync
        tick(1'b0, 1'b1, 1'b0, 8'h99);
        check("miss_err", 32'(frame_err), 32'h1);
        check("miss_locked", 32'(locked), 32'h0);
        check("miss_ch_a_hold", 32'(ch_a), 32'h50);
        send_frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1);
        check("relock_ch_a", 32'(ch_a), 32'hA1);
        check("relock_ch_d", 32'(ch_d), 32'hA4);

        // 256 frames wrap the counter; reset on the completing edge wins
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 256; f++)
            send_frame(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'h0);
        check("wrap_out_valid", 32'(out_valid), 32'h1);
        tick(1'b0, 1'b1, 1'b1, 8'hC1);
        tick(1'b0, 1'b1, 1'b0, 8'hC2);
        tick(1'b0, 1'b1, 1'b0, 8'hC3);
        tick(1'b1, 1'b1, 1'b0, 8'hC4);
        check("rst_slot3_ov", 32'(out_valid), 32'h0);
        check("rst_slot3_ch_a", 32'(ch_a), 32'h0);
        check("rst_slot3_ch_d", 32'(ch_d), 32'h0);
        check("rst_slot3_cnt", 32'(frame_cnt), 32'h0);
        tick(1'b0, 1'b1, 1'b0, 8'hC5);
        check("post_rst_needs_sof", 32'(locked), 32'h0);

        // Randomized traffic, mostly well-formed with occasional violations
        for (int i = 0; i < 4000; i++) begin
            bit r, v, s;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom % 4) != 0;
            if (m_frame.size() == 0) s = ($urandom % 8) != 0;
            else                     s = ($urandom % 16) == 0;
            tick(r, v, s, WIDTH'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
